// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC select and circular return-address stack
// Sticky error flags record stack overflow/underflow and illegal selects.
module pc_unit #(
  parameter int AddrWidth = 10,
  parameter int RasDepth  = 4,
  parameter logic [AddrWidth-1:0] ResetPc = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [2:0]                   pc_select,
  input  logic [13:0]                  imm_14bit,
  input  logic [23:0]                  imm_24bit,
  input  logic [AddrWidth-1:0]         reg_target,
  input  logic                         clear_err,
  output logic [AddrWidth-1:0]         current_pc,
  output logic [$clog2(RasDepth):0]    ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         illegal_sel
);

  localparam int PtrW = $clog2(RasDepth);
  localparam logic [PtrW:0] Full = (PtrW+1)'(RasDepth);

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'b000,
    SEL_BRANCH = 3'b001,
    SEL_JUMP   = 3'b010,
    SEL_CALL   = 3'b011,
    SEL_RET    = 3'b100,
    SEL_REG    = 3'b101
  } sel_e;

  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] ras_q [RasDepth];
  logic [AddrWidth-1:0] ras_d [RasDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]        count_q, count_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d, ill_q, ill_d;

  logic [AddrWidth-1:0] pc_plus4, br_off, jmp_off;
  logic                 set_ovf, set_udf, set_ill;

  // Displacements are halfword counts: sign-extend, shift, then fold to PC width.
  assign br_off   = AddrWidth'({{49{imm_14bit[13]}}, imm_14bit, 1'b0});
  assign jmp_off  = AddrWidth'({{39{imm_24bit[23]}}, imm_24bit, 1'b0});
  assign pc_plus4 = pc_q + AddrWidth'(4);

  always_comb begin
    pc_d     = pc_q;
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    set_ovf  = 1'b0;
    set_udf  = 1'b0;
    set_ill  = 1'b0;
    if (enable) begin
      case (pc_select)
        SEL_SEQ:    pc_d = pc_plus4;
        SEL_BRANCH: pc_d = pc_q + br_off;
        SEL_JUMP:   pc_d = pc_q + jmp_off;
        SEL_CALL: begin
          // When full, wr_ptr already points at the oldest entry.
          pc_d            = pc_q + jmp_off;
          ras_d[wr_ptr_q] = pc_plus4;
          wr_ptr_d        = wr_ptr_q + PtrW'(1);
          if (count_q == Full) set_ovf = 1'b1;
          else                 count_d = count_q + (PtrW+1)'(1);
        end
        SEL_RET: begin
          if (count_q == '0) begin
            pc_d    = pc_plus4;
            set_udf = 1'b1;
          end else begin
            pc_d     = ras_q[wr_ptr_q - PtrW'(1)];
            wr_ptr_d = wr_ptr_q - PtrW'(1);
            count_d  = count_q - (PtrW+1)'(1);
          end
        end
        SEL_REG:    pc_d = reg_target;
        default: begin
          pc_d    = pc_plus4;
          set_ill = 1'b1;
        end
      endcase
    end
    ovf_d = set_ovf | (ovf_q & ~clear_err);
    udf_d = set_udf | (udf_q & ~clear_err);
    ill_d = set_ill | (ill_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= ResetPc;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ill_q    <= ill_d;
    end
  end

  // Stack contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign current_pc    = pc_q;
  assign ras_count     = count_q;
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == Full);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;
  assign illegal_sel   = ill_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
// Flag vector order: {ras_empty, ras_full, ras_overflow, ras_underflow, illegal_sel}.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, enable, clear_err;
  logic [2:0]  pc_select;
  logic [13:0] imm_14bit;
  logic [23:0] imm_24bit;
  logic [9:0]  reg_target;
  logic [9:0]  current_pc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, illegal_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .pc_select(pc_select),
    .imm_14bit(imm_14bit), .imm_24bit(imm_24bit), .reg_target(reg_target),
    .clear_err(clear_err), .current_pc(current_pc), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .illegal_sel(illegal_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, then check state 1 time unit later.
  task automatic step(input logic r, input logic en, input logic [2:0] sel,
                      input logic clr, input string tag, input logic [9:0] exp_pc,
                      input logic [2:0] exp_cnt, input logic [4:0] exp_flags);
    rst = r; enable = en; pc_select = sel; clear_err = clr;
    @(posedge clk);
    #1;
    check({tag, ".pc"}, 32'(current_pc), 32'(exp_pc));
    check({tag, ".cnt"}, 32'(ras_count), 32'(exp_cnt));
    check({tag, ".flags"}, 32'({ras_empty, ras_full, ras_overflow, ras_underflow, illegal_sel}),
          32'(exp_flags));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pc_select = 3'd0; clear_err = 1'b0;
    imm_14bit = '0; imm_24bit = '0; reg_target = '0;
    #1;
    step(1, 1, 3'd0, 0, "reset",  10'h000, 3'd0, 5'b10000);
    step(0, 1, 3'd0, 0, "seq1",   10'h004, 3'd0, 5'b10000);
    step(0, 1, 3'd0, 0, "seq2",   10'h008, 3'd0, 5'b10000);
    step(0, 1, 3'd0, 0, "seq3",   10'h00C, 3'd0, 5'b10000);
    imm_14bit = 14'h3FFE;
    step(0, 1, 3'd1, 0, "br_neg", 10'h008, 3'd0, 5'b10000);
    imm_14bit = 14'h0010;
    step(0, 1, 3'd1, 0, "br_pos", 10'h028, 3'd0, 5'b10000);
    reg_target = 10'h020;
    step(0, 1, 3'd5, 0, "regjmp", 10'h020, 3'd0, 5'b10000);
    imm_24bit = 24'h000040;
    step(0, 1, 3'd3, 0, "call",   10'h0A0, 3'd1, 5'b00000);
    step(0, 1, 3'd4, 0, "ret",    10'h024, 3'd0, 5'b10000);
    step(0, 1, 3'd3, 0, "c1",     10'h0A4, 3'd1, 5'b00000);
    step(0, 1, 3'd3, 0, "c2",     10'h124, 3'd2, 5'b00000);
    step(0, 1, 3'd3, 0, "c3",     10'h1A4, 3'd3, 5'b00000);
    step(0, 1, 3'd3, 0, "c4",     10'h224, 3'd4, 5'b01000);
    step(0, 1, 3'd3, 0, "c5_ovf", 10'h2A4, 3'd4, 5'b01100);
    step(0, 1, 3'd4, 0, "r1",     10'h228, 3'd3, 5'b00100);
    step(0, 1, 3'd4, 0, "r2",     10'h1A8, 3'd2, 5'b00100);
    step(0, 1, 3'd4, 0, "r3",     10'h128, 3'd1, 5'b00100);
    step(0, 1, 3'd4, 0, "r4",     10'h0A8, 3'd0, 5'b10100);
    step(0, 1, 3'd4, 0, "r5_udf", 10'h0AC, 3'd0, 5'b10110);
    step(0, 0, 3'd0, 1, "clr",    10'h0AC, 3'd0, 5'b10000);
    step(0, 1, 3'd6, 0, "ill6",   10'h0B0, 3'd0, 5'b10001);
    step(0, 1, 3'd7, 0, "ill7",   10'h0B4, 3'd0, 5'b10001);
    step(0, 1, 3'd6, 1, "setwin", 10'h0B8, 3'd0, 5'b10001);
    step(0, 1, 3'd0, 1, "clr2",   10'h0BC, 3'd0, 5'b10000);
    reg_target = 10'h3FC;
    step(0, 1, 3'd5, 0, "to3fc",  10'h3FC, 3'd0, 5'b10000);
    step(0, 1, 3'd0, 0, "wrap",   10'h000, 3'd0, 5'b10000);
    step(0, 0, 3'd3, 0, "stall1", 10'h000, 3'd0, 5'b10000);
    step(0, 0, 3'd3, 0, "stall2", 10'h000, 3'd0, 5'b10000);
    step(0, 0, 3'd3, 0, "stall3", 10'h000, 3'd0, 5'b10000);
    imm_24bit = 24'hFFFFFE;
    step(0, 1, 3'd2, 0, "jmpneg", 10'h3FC, 3'd0, 5'b10000);
    step(0, 1, 3'd6, 0, "illwrp", 10'h000, 3'd0, 5'b10001);
    imm_24bit = 24'h000010;
    step(0, 1, 3'd3, 0, "pc1",    10'h020, 3'd1, 5'b00001);
    step(0, 1, 3'd3, 0, "pc2",    10'h040, 3'd2, 5'b00001);
    step(0, 0, 3'd4, 0, "stallr", 10'h040, 3'd2, 5'b00001);
    step(1, 1, 3'd3, 0, "rstcal", 10'h000, 3'd0, 5'b10000);
    step(0, 1, 3'd4, 0, "postrt", 10'h004, 3'd0, 5'b10010);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
